// File: rtl/kuznechik_key_sched_ctrl.sv
// ---------------------------------------------------------------------------
// kuznechik_key_sched_ctrl
//
// Sequences an external kuznechik_keygen through one master-key expansion,
// captures the five key pairs it produces into a ten-slot round-key store,
// and serves that store to two requesters (encryptor and decryptor) through
// a round-robin arbiter with a one-cycle read latency.
//
// Ports
//   clk            : clock, rising edge
//   rst_n          : synchronous active-low reset
//   key_load       : one-cycle request to expand master_key
//   master_key     : 256-bit master key, K1 = [255:128], K2 = [127:0]
//   kg_rst_n       : synchronous reset to the keygen (low for one CLR cycle)
//   kg_en          : keygen enable, high while expanding
//   kg_master_key  : latched master key presented to the keygen
//   kg_round_keys  : key pair from keygen, [255:128] odd key, [127:0] even key
//   kg_ready       : key pair valid strobe from keygen
//   busy           : expansion in progress
//   keys_valid     : all ten round keys stored
//   enc_req/enc_idx, dec_req/dec_idx : read requests from the two clients
//   enc_gnt/dec_gnt: combinational grants (at most one per cycle)
//   rd_key         : read data, valid the cycle after a grant
//   enc_rvalid/dec_rvalid : one-cycle read-return strobes
//
// Configuration
//   KUZ_KEYSTORE_ZEROIZE_EN : when defined, the key store is cleared on reset
//   and during the CLR cycle. When undefined the store has no reset and only
//   keys_valid protects stale contents.
// ---------------------------------------------------------------------------
module kuznechik_key_sched_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_load,
  input  logic [255:0] master_key,
  output logic         kg_rst_n,
  output logic         kg_en,
  output logic [255:0] kg_master_key,
  input  logic [255:0] kg_round_keys,
  input  logic         kg_ready,
  output logic         busy,
  output logic         keys_valid,
  input  logic         enc_req,
  input  logic [3:0]   enc_idx,
  input  logic         dec_req,
  input  logic [3:0]   dec_idx,
  output logic         enc_gnt,
  output logic         dec_gnt,
  output logic [127:0] rd_key,
  output logic         enc_rvalid,
  output logic         dec_rvalid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    RUN   = 2'd2,
    READY = 2'd3
  } state_t;

  state_t       state;
  logic [2:0]   pair_cnt;
  logic         prio_dec;
  logic         store_wr;
  logic [3:0]   rd_idx;
  logic [127:0] rd_mux;
  logic [127:0] key_store [10];

  // Expansion sequencer. All keygen-facing controls are registered so the
  // keygen sees clean, glitch-free levels. A key_load is only accepted from
  // IDLE or READY; loads during CLR/RUN are dropped rather than queued.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      kg_rst_n      <= 1'b0;
      kg_en         <= 1'b0;
      busy          <= 1'b0;
      keys_valid    <= 1'b0;
      pair_cnt      <= 3'd0;
      kg_master_key <= '0;
    end else begin
      case (state)
        IDLE, READY: begin
          if (key_load) begin
            kg_master_key <= master_key;
            keys_valid    <= 1'b0;
            kg_rst_n      <= 1'b0;
            kg_en         <= 1'b0;
            pair_cnt      <= 3'd0;
            state         <= CLR;
          end
        end
        CLR: begin
          pair_cnt <= 3'd0;
          kg_rst_n <= 1'b1;
          kg_en    <= 1'b1;
          busy     <= 1'b1;
          state    <= RUN;
        end
        RUN: begin
          if (kg_ready) begin
            // The fifth pair completes the schedule.
            if (pair_cnt == 3'd4) begin
              kg_en      <= 1'b0;
              busy       <= 1'b0;
              keys_valid <= 1'b1;
              state      <= READY;
            end else begin
              pair_cnt <= pair_cnt + 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pairs are only accepted while RUN; strobes in any other state are ignored.
  assign store_wr = (state == RUN) && kg_ready;

  // Round-key store. Pair n lands in slots 2n (odd key) and 2n+1 (even key).
`ifdef KUZ_KEYSTORE_ZEROIZE_EN
  always_ff @(posedge clk) begin
    if (!rst_n || (state == CLR)) begin
      for (int i = 0; i < 10; i++) begin
        key_store[i] <= '0;
      end
    end else if (store_wr) begin
      for (int i = 0; i < 5; i++) begin
        if (pair_cnt == 3'(i)) begin
          key_store[2*i]   <= kg_round_keys[255:128];
          key_store[2*i+1] <= kg_round_keys[127:0];
        end
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst_n && store_wr) begin
      for (int i = 0; i < 5; i++) begin
        if (pair_cnt == 3'(i)) begin
          key_store[2*i]   <= kg_round_keys[255:128];
          key_store[2*i+1] <= kg_round_keys[127:0];
        end
      end
    end
  end
`endif

  // Grant logic: nothing is granted until the whole schedule is in place.
  // Under contention the priority holder wins; prio_dec=0 means enc holds it.
  assign enc_gnt = keys_valid && enc_req && (!dec_req || !prio_dec);
  assign dec_gnt = keys_valid && dec_req && (!enc_req ||  prio_dec);

  assign rd_idx = dec_gnt ? dec_idx : enc_idx;

  // Out-of-range indices (10..15) match no slot and read back as zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < 10; i++) begin
      if (rd_idx == 4'(i)) begin
        rd_mux = key_store[i];
      end
    end
  end

  // Read return and priority rotation. rd_key holds its last value between
  // reads; the rvalid strobes qualify it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_key     <= '0;
      enc_rvalid <= 1'b0;
      dec_rvalid <= 1'b0;
      prio_dec   <= 1'b0;
    end else begin
      enc_rvalid <= enc_gnt;
      dec_rvalid <= dec_gnt;
      if (enc_gnt || dec_gnt) begin
        rd_key <= rd_mux;
      end
      if (keys_valid && enc_req && dec_req) begin
        prio_dec <= ~prio_dec;
      end
    end
  end

endmodule

// File: tb/tb_kuznechik_key_sched_ctrl.sv
// ---------------------------------------------------------------------------
// tb_kuznechik_key_sched_ctrl
//
// Directed bench for kuznechik_key_sched_ctrl. The bench plays the role of
// the keygen (driving kg_ready / kg_round_keys from fixed pair tables) and
// of both key-store clients. Expected read returns are queued when a grant
// is expected; an independent monitor pops and compares whenever an rvalid
// strobe appears.
// ---------------------------------------------------------------------------
module tb_kuznechik_key_sched_ctrl;

  logic         clk;
  logic         rst_n;
  logic         key_load;
  logic [255:0] master_key;
  logic         kg_rst_n;
  logic         kg_en;
  logic [255:0] kg_master_key;
  logic [255:0] kg_round_keys;
  logic         kg_ready;
  logic         busy;
  logic         keys_valid;
  logic         enc_req;
  logic [3:0]   enc_idx;
  logic         dec_req;
  logic [3:0]   dec_idx;
  logic         enc_gnt;
  logic         dec_gnt;
  logic [127:0] rd_key;
  logic         enc_rvalid;
  logic         dec_rvalid;

  typedef struct packed {
    logic         is_dec;
    logic [127:0] key;
  } exp_t;

  exp_t         exp_q [$];
  int           tests_run;
  int           tests_failed;
  logic [255:0] pairs [3][5];

  localparam logic [255:0] MK_A = {128'h8899aabbccddeeff0011223344556677,
                                   128'hfedcba98765432100123456789abcdef};
  localparam logic [255:0] MK_B = {128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0,
                                   128'h00112233445566778899aabbccddeeff};
  localparam logic [255:0] MK_C = {128'hcafef00ddeadbeef0123456789abcdef,
                                   128'h13579bdf2468ace013579bdf2468ace0};

  localparam logic [127:0] SLOT0_A = 128'h8899aabbccddeeff0011223344556677;
  localparam logic [127:0] SLOT2_A = 128'h3e109d47585364fe5d26cab3b2b7c914;
  localparam logic [127:0] SLOT9_A = 128'h4c9131375a1b2c3d4e5f60718293b40e;

  kuznechik_key_sched_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_load      (key_load),
    .master_key    (master_key),
    .kg_rst_n      (kg_rst_n),
    .kg_en         (kg_en),
    .kg_master_key (kg_master_key),
    .kg_round_keys (kg_round_keys),
    .kg_ready      (kg_ready),
    .busy          (busy),
    .keys_valid    (keys_valid),
    .enc_req       (enc_req),
    .enc_idx       (enc_idx),
    .dec_req       (dec_req),
    .dec_idx       (dec_idx),
    .enc_gnt       (enc_gnt),
    .dec_gnt       (dec_gnt),
    .rd_key        (rd_key),
    .enc_rvalid    (enc_rvalid),
    .dec_rvalid    (dec_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slot k of a table holds the odd key of pair k/2 for even k, else the even key.
  function automatic logic [127:0] slot_of(input int set, input int k);
    logic [255:0] p;
    p = pairs[set][k/2];
    return (k % 2 == 0) ? p[255:128] : p[127:0];
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] actual,
                             input logic [255:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request cycle (caller aligned just after a rising edge), check
  // the combinational grants mid-cycle and queue the expected read returns.
  task automatic applyStimulus(input logic e_req, input logic [3:0] e_idx,
                               input logic d_req, input logic [3:0] d_idx,
                               input logic exp_e, input logic exp_d,
                               input logic [127:0] e_key,
                               input logic [127:0] d_key, input string tag);
    exp_t e;
    enc_req = e_req;
    enc_idx = e_idx;
    dec_req = d_req;
    dec_idx = d_idx;
    @(negedge clk);
    checkOutput({tag, "_enc_gnt"}, 256'(enc_gnt), 256'(exp_e));
    checkOutput({tag, "_dec_gnt"}, 256'(dec_gnt), 256'(exp_d));
    if (exp_e) begin
      e.is_dec = 1'b0;
      e.key    = e_key;
      exp_q.push_back(e);
    end
    if (exp_d) begin
      e.is_dec = 1'b1;
      e.key    = d_key;
      exp_q.push_back(e);
    end
    tick();
    enc_req = 1'b0;
    dec_req = 1'b0;
  endtask

  task automatic load_key(input logic [255:0] mk);
    key_load   = 1'b1;
    master_key = mk;
    tick();
    key_load   = 1'b0;
  endtask

  task automatic wait_kg_en(input string tag);
    int n;
    n = 0;
    while (!kg_en && n < 20) begin
      tick();
      n++;
    end
    checkOutput({tag, "_kg_en_up"}, 256'(kg_en), 256'(1'b1));
  endtask

  task automatic send_pairs(input int set, input int first, input int count);
    for (int i = first; i < first + count; i++) begin
      kg_ready      = 1'b1;
      kg_round_keys = pairs[set][i];
      tick();
      kg_ready = 1'b0;
    end
  endtask

  // Scoreboard monitor: every rvalid strobe must match the oldest queued read.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (enc_rvalid && dec_rvalid) begin
        checkOutput("single_rvalid", 256'({enc_rvalid, dec_rvalid}), 256'(2'b01));
      end else if (enc_rvalid || dec_rvalid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_rvalid", 256'(dec_rvalid), 256'(1'b0));
        end else begin
          e = exp_q.pop_front();
          checkOutput("rvalid_port", 256'(dec_rvalid), 256'(e.is_dec));
          checkOutput("rd_key", 256'(rd_key), 256'(e.key));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    tests_run    = 0;
    tests_failed = 0;

    pairs[0][0] = MK_A;
    pairs[0][1] = {SLOT2_A, 128'h1111222233334444555566667777aaaa};
    pairs[0][2] = {128'ha1a2a3a4a5a6a7a8a9aaabacadaeafb0, 128'h0102030405060708090a0b0c0d0e0f10};
    pairs[0][3] = {128'h5555aaaa5555aaaa5555aaaa5555aaaa, 128'h2468ace02468ace02468ace02468ace0};
    pairs[0][4] = {128'hdeadbeefdeadbeefdeadbeefdeadbeef, SLOT9_A};
    for (int i = 0; i < 5; i++) begin
      pairs[1][i] = {8'h10 + 8'(i), 120'h0, 8'h20 + 8'(i), 120'h0} ^ MK_B;
      pairs[2][i] = {8'h30 + 8'(i), 120'h0, 8'h40 + 8'(i), 120'h0} ^ MK_C;
    end

    rst_n         = 1'b0;
    key_load      = 1'b0;
    master_key    = '0;
    kg_round_keys = '0;
    kg_ready      = 1'b0;
    enc_req       = 1'b0;
    enc_idx       = 4'd0;
    dec_req       = 1'b0;
    dec_idx       = 4'd0;

    // Reset values.
    repeat (3) tick();
    @(negedge clk);
    checkOutput("rst_kg_rst_n", 256'(kg_rst_n), 256'(1'b0));
    checkOutput("rst_kg_en", 256'(kg_en), 256'(1'b0));
    checkOutput("rst_busy", 256'(busy), 256'(1'b0));
    checkOutput("rst_keys_valid", 256'(keys_valid), 256'(1'b0));
    checkOutput("rst_kg_master_key", kg_master_key, 256'(0));
    checkOutput("rst_rd_key", 256'(rd_key), 256'(0));
    checkOutput("rst_rvalids", 256'({enc_rvalid, dec_rvalid}), 256'(0));
    tick();
    rst_n = 1'b1;

    // First expansion with the reference master key.
    load_key(MK_A);
    @(negedge clk);
    checkOutput("clr_kg_rst_n", 256'(kg_rst_n), 256'(1'b0));
    checkOutput("clr_kg_en", 256'(kg_en), 256'(1'b0));
    checkOutput("clr_master_key", kg_master_key, MK_A);
    wait_kg_en("run_a");
    checkOutput("run_busy", 256'(busy), 256'(1'b1));
    checkOutput("run_kg_rst_n", 256'(kg_rst_n), 256'(1'b1));
    applyStimulus(1'b1, 4'd0, 1'b1, 4'd9, 1'b0, 1'b0, '0, '0, "req_during_run");
    send_pairs(0, 0, 4);
    @(negedge clk);
    checkOutput("four_pairs_not_valid", 256'(keys_valid), 256'(1'b0));
    tick();
    send_pairs(0, 4, 1);
    @(negedge clk);
    checkOutput("done_keys_valid", 256'(keys_valid), 256'(1'b1));
    checkOutput("done_busy", 256'(busy), 256'(1'b0));
    checkOutput("done_kg_en", 256'(kg_en), 256'(1'b0));
    tick();

    // Single requester, then contended requests alternating from enc.
    applyStimulus(1'b1, 4'd2, 1'b0, 4'd0, 1'b1, 1'b0, SLOT2_A, '0, "enc_idx2");
    applyStimulus(1'b1, 4'd0, 1'b1, 4'd9, 1'b1, 1'b0, SLOT0_A, '0, "rr0");
    applyStimulus(1'b1, 4'd0, 1'b1, 4'd9, 1'b0, 1'b1, '0, SLOT9_A, "rr1");
    applyStimulus(1'b1, 4'd0, 1'b1, 4'd9, 1'b1, 1'b0, SLOT0_A, '0, "rr2");
    applyStimulus(1'b1, 4'd0, 1'b1, 4'd9, 1'b0, 1'b1, '0, SLOT9_A, "rr3");

    // Out-of-range indices still grant and return zero.
    applyStimulus(1'b1, 4'd12, 1'b0, 4'd0, 1'b1, 1'b0, '0, '0, "enc_idx12");
    applyStimulus(1'b0, 4'd0, 1'b1, 4'd15, 1'b0, 1'b1, '0, '0, "dec_idx15");

    // kg_ready outside RUN must not disturb the store.
    kg_ready      = 1'b1;
    kg_round_keys = {256{1'b1}};
    tick();
    kg_ready = 1'b0;
    applyStimulus(1'b0, 4'd0, 1'b1, 4'd1, 1'b0, 1'b1, '0, slot_of(0, 1), "store_hold");

    // key_load in the same cycle as a granted read: old key still returned.
    key_load   = 1'b1;
    master_key = MK_B;
    applyStimulus(1'b1, 4'd2, 1'b0, 4'd0, 1'b1, 1'b0, SLOT2_A, '0, "load_race");
    key_load = 1'b0;
    @(negedge clk);
    checkOutput("reload_keys_valid", 256'(keys_valid), 256'(1'b0));
    checkOutput("reload_kg_rst_n_pulse", 256'(kg_rst_n), 256'(1'b0));
    checkOutput("reload_master_key", kg_master_key, MK_B);
    wait_kg_en("run_b");

    // key_load during RUN is ignored.
    send_pairs(1, 0, 2);
    load_key(MK_C);
    @(negedge clk);
    checkOutput("ignored_load_key", kg_master_key, MK_B);
    checkOutput("ignored_load_busy", 256'(busy), 256'(1'b1));
    checkOutput("ignored_load_kg_rst_n", 256'(kg_rst_n), 256'(1'b1));
    tick();
    send_pairs(1, 2, 3);
    @(negedge clk);
    checkOutput("b_keys_valid", 256'(keys_valid), 256'(1'b1));
    tick();
    applyStimulus(1'b1, 4'd0, 1'b1, 4'd9, 1'b1, 1'b0, slot_of(1, 0), '0, "b_rr0");
    applyStimulus(1'b1, 4'd7, 1'b0, 4'd0, 1'b1, 1'b0, slot_of(1, 7), '0, "b_idx7");

    // Reset in the middle of RUN aborts everything; priority returns to enc.
    load_key(MK_C);
    wait_kg_en("run_c_partial");
    send_pairs(2, 0, 2);
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    checkOutput("midrst_keys_valid", 256'(keys_valid), 256'(1'b0));
    checkOutput("midrst_busy", 256'(busy), 256'(1'b0));
    checkOutput("midrst_kg_en", 256'(kg_en), 256'(1'b0));
    checkOutput("midrst_kg_rst_n", 256'(kg_rst_n), 256'(1'b0));
    checkOutput("midrst_master_key", kg_master_key, 256'(0));
    checkOutput("midrst_rd_key", 256'(rd_key), 256'(0));
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0, '0, '0, "no_gnt_after_rst");
    repeat (3) tick();
    @(negedge clk);
    checkOutput("partial_never_valid", 256'(keys_valid), 256'(1'b0));
    tick();
    load_key(MK_C);
    wait_kg_en("run_c");
    applyStimulus(1'b1, 4'd0, 1'b1, 4'd1, 1'b0, 1'b0, '0, '0, "no_stale_read");
    send_pairs(2, 0, 5);
    @(negedge clk);
    checkOutput("c_keys_valid", 256'(keys_valid), 256'(1'b1));
    tick();
    applyStimulus(1'b1, 4'd0, 1'b1, 4'd9, 1'b1, 1'b0, slot_of(2, 0), '0, "prio_after_rst");
    applyStimulus(1'b1, 4'd0, 1'b1, 4'd9, 1'b0, 1'b1, '0, slot_of(2, 9), "prio_alt");

    repeat (3) tick();
    checkOutput("scoreboard_drained", 256'(exp_q.size()), 256'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/kuznechik_key_sched_ctrl.md
KUZNECHIK_KEY_SCHED_CTRL -- requirements
Module: kuznechik_key_sched_ctrl

Interface
REQ-001 Port clk, input, 1: clock; all logic on rising edge.
REQ-002 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-003 Port key_load, input, 1: one-cycle request to expand master_key.
REQ-004 Port master_key, input, 256: K1 = [255:128], K2 = [127:0]; sampled when key_load is accepted.
REQ-005 Port kg_rst_n, output, 1: synchronous reset to kuznechik_keygen.
REQ-006 Port kg_en, output, 1: enable to kuznechik_keygen.
REQ-007 Port kg_master_key, output, 256: latched master key driven to kuznechik_keygen.
REQ-008 Port kg_round_keys, input, 256: key pair from keygen; [255:128] is the odd key, [127:0] the even key.
REQ-009 Port kg_ready, input, 1: pair valid strobe from keygen.
REQ-010 Port busy, output, 1: expansion in progress.
REQ-011 Port keys_valid, output, 1: all 10 round keys stored.
REQ-012 Ports enc_req (1), enc_idx (4), dec_req (1), dec_idx (4), inputs: two requesters of the key store.
REQ-013 Ports enc_gnt (1), dec_gnt (1), rd_key (128), enc_rvalid (1), dec_rvalid (1), outputs: arbitration and read return.

Function
REQ-014 FSM states: IDLE, CLR, RUN, READY; reset state IDLE.
REQ-015 IDLE or READY with key_load=1: latch master_key into kg_master_key, drop keys_valid, go to CLR.
REQ-016 CLR lasts one cycle: kg_rst_n=0, kg_en=0, pair counter=0; then go to RUN.
REQ-017 RUN: kg_rst_n=1, kg_en=1, busy=1.
REQ-018 RUN, each kg_ready: store [255:128] at slot 2*cnt and [127:0] at slot 2*cnt+1; cnt increments.
REQ-019 RUN, kg_ready with cnt=4: store the pair, go to READY; next cycle kg_en=0, busy=0, keys_valid=1.
REQ-020 key_load in CLR or RUN is ignored; no queuing.
REQ-021 kg_ready outside RUN is ignored; the store is unchanged.
REQ-022 Requests are granted only when keys_valid=1; otherwise enc_gnt=dec_gnt=0 and the requests are not remembered.
REQ-023 At most one grant per cycle; the grant is combinational from req and priority.
REQ-024 With a single requester active, that requester is granted.
REQ-025 With both requesting, grant the priority holder; priority passes to the other requester after every contended grant.
REQ-026 After reset, priority is held by enc.
REQ-027 Read latency is 1 cycle: the cycle after a grant, rd_key = store[idx], and enc_rvalid or dec_rvalid pulses for 1 cycle.
REQ-028 idx > 9 still grants and returns rd_key = 0.
REQ-029 key_load arriving in the same cycle as a granted read still returns the old key next cycle; the store is then frozen by keys_valid=0.

Reset
REQ-030 While rst_n=0 at a clock edge: state=IDLE, kg_rst_n=0, kg_en=0, busy=0, keys_valid=0.
REQ-031 Reset also forces: gnts=0, rvalids=0, rd_key=0, priority=enc, cnt=0, kg_master_key=0.
REQ-032 Reset mid-RUN aborts expansion; a partial store is never flagged valid.

Configuration
REQ-033 Macro KUZ_KEYSTORE_ZEROIZE_EN, defined: all 10 store slots are cleared to 0 on reset and in the CLR cycle.
REQ-034 Macro KUZ_KEYSTORE_ZEROIZE_EN, undefined: store slots have no reset and keep stale data until overwritten; only keys_valid guards access.

Verification
REQ-035 Load {8899aabbccddeeff0011223344556677, fedcba98765432100123456789abcdef} -> after 5 kg_ready pulses keys_valid=1; slot0=8899aabb...6677, slot9=4c913137...b40e.
REQ-036 After REQ-035, enc_req with idx=2 alone -> enc_gnt=1; next cycle rd_key=3e109d47585364fe5d26cab3b2b7c914, enc_rvalid=1.
REQ-037 enc_req and dec_req held 4 cycles, idx 0 and 9 -> grants alternate enc, dec, enc, dec; returns 8899aabb... and 4c913137... in matching order.
REQ-038 key_load mid-RUN after 2 pairs -> ignored; after 5 pairs keys_valid=1; then key_load -> keys_valid=0 next cycle, one-cycle kg_rst_n pulse.
REQ-039 rst_n=0 during RUN -> all outputs at reset values; with KUZ_KEYSTORE_ZEROIZE_EN, idx=0 read after a new load returns the new key, with no stale data visible before keys_valid=1.
REQ-040 Read idx=12 -> granted; rd_key=0 with rvalid=1.
